// File: rtl/tl_ul_pkg.sv
// Shared TL-UL opcodes, slave FSM encoding and the size/address-to-byte-lane helper.
package tl_ul_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} tl_state_e;

    // Lanes covered by a 2**size byte transfer starting at byte lane 'lane'.
    function automatic logic [7:0] size_to_mask(input logic [2:0] size, input logic [2:0] lane);
        logic [7:0] span;
        if (size > 3'd3) begin
            span = 8'h00;
        end else begin
            span = 8'((32'd1 << (32'd1 << size)) - 32'd1);
        end
        return span << lane;
    endfunction

endpackage

// File: rtl/tl_ram_array.sv
// Single-port synchronous SRAM with per-byte write enables and a one-cycle registered read.
module tl_ram_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           req,
    input  logic                           we,
    input  logic [DATA_WIDTH/8-1:0]        be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (req) begin
            if (we) begin
                for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/tl_ul_ram_slave.sv
// TL-UL SRAM slave: one outstanding Get/Put, legality checking, registered Channel D response.
// Optional TL_RAM_PERF_CNT_EN adds saturating read/write/error completion counters.
module tl_ul_ram_slave
    import tl_ul_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned           SIZE_WIDTH   = 3,
    parameter int unsigned           OPCODE_WIDTH = 3,
    parameter int unsigned           PARAM_WIDTH  = 3,
    parameter int unsigned           DEPTH_WORDS  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic                    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic                    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
`ifdef TL_RAM_PERF_CNT_EN
    ,
    output logic [31:0]             perf_reads,
    output logic [31:0]             perf_writes,
    output logic [31:0]             perf_errors
`endif
);

    localparam int unsigned LOG_MASK  = $clog2(MASK_WIDTH);
    localparam int unsigned IDX_WIDTH = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WINDOW_BYTES = ADDR_WIDTH'(DEPTH_WORDS * MASK_WIDTH);

    tl_state_e state_q, state_d;

    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic                    source_q;
    logic [IDX_WIDTH-1:0]    index_q;
    logic [MASK_WIDTH-1:0]   mask_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    err_q;

    logic                    accept;
    logic                    ram_req;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    is_get_q;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [MASK_WIDTH-1:0]   span;
    logic                    op_ok, size_ok, align_ok, range_ok, mask_ok, req_err;

    // Below-base addresses wrap to large offsets and fail the window compare.
    always_comb begin
        offset   = a_address - BASE_ADDR;
        op_ok    = (a_opcode == OPCODE_WIDTH'(TL_PUT_FULL))    ||
                   (a_opcode == OPCODE_WIDTH'(TL_PUT_PARTIAL)) ||
                   (a_opcode == OPCODE_WIDTH'(TL_GET));
        size_ok  = a_size <= SIZE_WIDTH'(LOG_MASK);
        align_ok = (a_address & ((ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1))) == '0;
        range_ok = offset < WINDOW_BYTES;
        span     = MASK_WIDTH'(size_to_mask(3'(a_size), 3'(a_address[LOG_MASK-1:0])));
        mask_ok  = ((a_mask & ~span) == '0) &&
                   ((a_opcode != OPCODE_WIDTH'(TL_PUT_FULL)) || (a_mask == span));
        req_err  = !(op_ok && (a_param == '0) && size_ok && align_ok && range_ok && mask_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_ready = 1'b0;
        d_valid = 1'b0;
        ram_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                a_ready = 1'b1;
                if (a_valid) state_d = StAccess;
            end
            StAccess: begin
                ram_req = !err_q;
                state_d = StResp;
            end
            StResp: begin
                d_valid = 1'b1;
                if (d_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = a_valid && a_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
            size_q   <= '0;
            source_q <= 1'b0;
            index_q  <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            opcode_q <= a_opcode;
            size_q   <= a_size;
            source_q <= a_source;
            index_q  <= offset[LOG_MASK +: IDX_WIDTH];
            mask_q   <= a_mask;
            data_q   <= a_data;
            err_q    <= req_err;
        end
    end

    assign is_get_q = opcode_q == OPCODE_WIDTH'(TL_GET);

    tl_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .req  (ram_req),
        .we   (!is_get_q),
        .be   (mask_q),
        .addr (index_q),
        .wdata(data_q),
        .rdata(ram_rdata)
    );

    // The array output register only changes on a read, so it holds through RESP.
    assign d_opcode = is_get_q ? OPCODE_WIDTH'(TL_ACCESS_ACK_DATA) : OPCODE_WIDTH'(TL_ACCESS_ACK);
    assign d_param  = '0;
    assign d_size   = size_q;
    assign d_source = source_q;
    assign d_sink   = 1'b0;
    assign d_error  = err_q;
    assign d_data   = (d_valid && is_get_q && !err_q) ? ram_rdata : '0;

`ifdef TL_RAM_PERF_CNT_EN
    logic resp_done;
    assign resp_done = d_valid && d_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_errors <= '0;
        end else if (resp_done) begin
            if (err_q) begin
                if (perf_errors != '1) perf_errors <= perf_errors + 32'd1;
            end else if (is_get_q) begin
                if (perf_reads != '1) perf_reads <= perf_reads + 32'd1;
            end else begin
                if (perf_writes != '1) perf_writes <= perf_writes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tl_ul_ram_slave.sv
// Directed bench for tl_ul_ram_slave; perf counter checks build when TL_RAM_PERF_CNT_EN is set.
module tb_tl_ul_ram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
`ifdef TL_RAM_PERF_CNT_EN
    logic [31:0] perf_reads;
    logic [31:0] perf_writes;
    logic [31:0] perf_errors;
`endif

    always #5 clk = ~clk;

    tl_ul_ram_slave dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_param  (a_param),
        .a_size   (a_size),
        .a_source (a_source),
        .a_address(a_address),
        .a_mask   (a_mask),
        .a_data   (a_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_opcode (d_opcode),
        .d_param  (d_param),
        .d_size   (d_size),
        .d_source (d_source),
        .d_sink   (d_sink),
        .d_data   (d_data),
        .d_error  (d_error)
`ifdef TL_RAM_PERF_CNT_EN
        ,
        .perf_reads (perf_reads),
        .perf_writes(perf_writes),
        .perf_errors(perf_errors)
`endif
    );

    int checks = 0;
    int passes = 0;

    logic [2:0]  r_op;
    logic        r_err;
    logic [31:0] r_data;
    logic [2:0]  r_size;
    logic        r_src;
    logic [2:0]  r_prm;
    logic        r_snk;
    int          r_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge, then complete the response with d_ready.
    task automatic xact(input string tag, input logic [2:0] op, input logic [2:0] prm,
                        input logic [2:0] size, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic src);
        int n;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = prm;
        a_size    = size;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_source  = src;
        d_ready   = 1'b0;
        n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        r_lat = 1;
        while (!d_valid && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
        end
        check({tag, "_dvalid"}, 64'(d_valid), 64'd1);
        r_op   = d_opcode;
        r_err  = d_error;
        r_data = d_data;
        r_size = d_size;
        r_src  = d_source;
        r_prm  = d_param;
        r_snk  = d_sink;
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_param   = '0;
        a_size    = '0;
        a_source  = 1'b0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        d_ready   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_a_ready", 64'(a_ready), 64'd1);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_d_opcode", 64'(d_opcode), 64'd0);
        check("rst_d_data", 64'(d_data), 64'd0);
        check("rst_d_error", 64'(d_error), 64'd0);
        check("rst_d_size", 64'(d_size), 64'd0);
        check("rst_d_source", 64'(d_source), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        xact("put_full", 3'd0, 3'd0, 3'd2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        check("put_full_lat", 64'(r_lat), 64'd2);
        check("put_full_op", 64'(r_op), 64'd0);
        check("put_full_err", 64'(r_err), 64'd0);
        check("put_full_data", 64'(r_data), 64'd0);
        check("put_full_size", 64'(r_size), 64'd2);
        check("put_full_src", 64'(r_src), 64'd1);
        check("put_full_param", 64'(r_prm), 64'd0);
        check("put_full_sink", 64'(r_snk), 64'd0);

        xact("get1", 3'd4, 3'd0, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        check("get1_op", 64'(r_op), 64'd1);
        check("get1_err", 64'(r_err), 64'd0);
        check("get1_data", 64'(r_data), 64'hDEADBEEF);
        check("get1_src", 64'(r_src), 64'd0);

        xact("put_part", 3'd1, 3'd0, 3'd2, 32'h10, 4'b0010, 32'h0000AA00, 1'b0);
        check("put_part_op", 64'(r_op), 64'd0);
        check("put_part_err", 64'(r_err), 64'd0);
        xact("get2", 3'd4, 3'd0, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        check("get2_data", 64'(r_data), 64'hDEADAAEF);

        xact("get_misal", 3'd4, 3'd0, 3'd2, 32'h401, 4'hF, 32'h0, 1'b0);
        check("get_misal_op", 64'(r_op), 64'd1);
        check("get_misal_err", 64'(r_err), 64'd1);
        check("get_misal_data", 64'(r_data), 64'd0);
        xact("get_oob", 3'd4, 3'd0, 3'd2, 32'h400, 4'hF, 32'h0, 1'b0);
        check("get_oob_err", 64'(r_err), 64'd1);
        check("get_oob_data", 64'(r_data), 64'd0);
        xact("bad_param", 3'd4, 3'd1, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        check("bad_param_err", 64'(r_err), 64'd1);
        xact("bad_size", 3'd4, 3'd0, 3'd3, 32'h10, 4'hF, 32'h0, 1'b0);
        check("bad_size_err", 64'(r_err), 64'd1);
        xact("pf_mask", 3'd0, 3'd0, 3'd2, 32'h10, 4'h3, 32'hFFFFFFFF, 1'b0);
        check("pf_mask_err", 64'(r_err), 64'd1);
        check("pf_mask_op", 64'(r_op), 64'd0);
        xact("pp_lane", 3'd1, 3'd0, 3'd1, 32'h12, 4'b0001, 32'hFFFFFFFF, 1'b0);
        check("pp_lane_err", 64'(r_err), 64'd1);
        xact("bad_op", 3'd7, 3'd0, 3'd2, 32'h10, 4'hF, 32'hFFFFFFFF, 1'b0);
        check("bad_op_op", 64'(r_op), 64'd0);
        check("bad_op_err", 64'(r_err), 64'd1);

        xact("pp_half", 3'd1, 3'd0, 3'd1, 32'h12, 4'b1100, 32'h12340000, 1'b0);
        check("pp_half_err", 64'(r_err), 64'd0);
        xact("pf_byte", 3'd0, 3'd0, 3'd0, 32'h13, 4'b1000, 32'h77000000, 1'b0);
        check("pf_byte_err", 64'(r_err), 64'd0);
        xact("get3", 3'd4, 3'd0, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        check("get3_data", 64'(r_data), 64'h7734AAEF);

        xact("pf_top", 3'd0, 3'd0, 3'd2, 32'h3FC, 4'hF, 32'hCAFEF00D, 1'b0);
        check("pf_top_err", 64'(r_err), 64'd0);
        xact("get_top", 3'd4, 3'd0, 3'd2, 32'h3FC, 4'hF, 32'h0, 1'b0);
        check("get_top_err", 64'(r_err), 64'd0);
        check("get_top_data", 64'(r_data), 64'hCAFEF00D);

        // Backpressure: response held, second request stalled until the handshake.
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_param   = 3'd0;
        a_size    = 3'd2;
        a_address = 32'h10;
        a_mask    = 4'hF;
        d_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_address = 32'h3FC;
        n = 0;
        while (!d_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_dvalid", 64'(d_valid), 64'd1);
            check("stall_data", 64'(d_data), 64'h7734AAEF);
            check("stall_opcode", 64'(d_opcode), 64'd1);
            check("stall_a_ready", 64'(a_ready), 64'd0);
            @(negedge clk);
        end
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_a_ready", 64'(a_ready), 64'd1);
        check("post_hs_dvalid", 64'(d_valid), 64'd0);
        d_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        n = 0;
        while (!d_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("second_dvalid", 64'(d_valid), 64'd1);
        check("second_data", 64'(d_data), 64'hCAFEF00D);
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;

        // Reset while a response is pending.
        a_valid   = 1'b1;
        a_address = 32'h10;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        n = 0;
        while (!d_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rr_dvalid_before", 64'(d_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("rr_dvalid_async", 64'(d_valid), 64'd0);
        check("rr_a_ready_async", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        check("rr_dvalid_edge", 64'(d_valid), 64'd0);
        check("rr_a_ready_edge", 64'(a_ready), 64'd1);
        @(negedge clk);
        reset   = 1'b1;
        d_ready = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_valid) n++;
        end
        check("rr_no_stale", 64'(n), 64'd0);
        d_ready = 1'b0;

`ifdef TL_RAM_PERF_CNT_EN
        check("perf_rst_reads", 64'(perf_reads), 64'd0);
        check("perf_rst_writes", 64'(perf_writes), 64'd0);
        check("perf_rst_errors", 64'(perf_errors), 64'd0);
        for (int i = 0; i < 3; i++) begin
            xact("perf_get", 3'd4, 3'd0, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            xact("perf_put", 3'd0, 3'd0, 3'd2, 32'h20, 4'hF, 32'h5, 1'b0);
        end
        xact("perf_bad", 3'd7, 3'd0, 3'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        check("perf_reads", 64'(perf_reads), 64'd3);
        check("perf_writes", 64'(perf_writes), 64'd2);
        check("perf_errors", 64'(perf_errors), 64'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
